// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired datapath controller:
// opcodes, state encoding, IR field positions and opcode classification.
package cpu_defs_pkg;

  localparam int OPC_W    = 5;
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 16;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T5   = 4'd6;
  localparam logic [3:0] ST_T6   = 4'd7;
  localparam logic [3:0] ST_HALT = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE = ST_IDLE,
    S_T0   = ST_T0,
    S_T1   = ST_T1,
    S_T2   = ST_T2,
    S_T3   = ST_T3,
    S_T4   = ST_T4,
    S_T5   = ST_T5,
    S_T6   = ST_T6,
    S_HALT = ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_BINARY,
    CLS_UNARY,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify_op(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL, OP_MUL, OP_DIV: classify_op = CLS_BINARY;
      OP_NEG, OP_NOT:                          classify_op = CLS_UNARY;
      OP_NOP:                                  classify_op = CLS_NOP;
      OP_HALT:                                 classify_op = CLS_HALT;
      default:                                 classify_op = CLS_ILLEGAL;
    endcase
  endfunction

  // mul/div write a 64-bit product/quotient pair and need the extra HI cycle.
  function automatic logic is_muldiv(input logic [OPC_W-1:0] opc);
    is_muldiv = (opc == OP_MUL) || (opc == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot general-purpose-register select; all zero when disabled.
module reg_select_decoder
  import cpu_defs_pkg::*;
(
  input  logic [REG_W-1:0]    idx_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_control_unit.sv
// Hardwired Moore controller sequencing the datapath through fetch (T0-T2),
// decode (T3) and execute (T4-T6) for ALU, mul/div, nop and halt instructions.
module alu_control_unit
  import cpu_defs_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [OPC_W-1:0] opcode;
  logic [REG_W-1:0] ra, rb, rc;
  op_class_e        op_class;
  logic             op_muldiv;

  logic             rin_en, rout_en;
  logic [REG_W-1:0] rin_idx, rout_idx;

  logic unused_ir_bits;

  assign opcode    = IR[OPC_LSB +: OPC_W];
  assign ra        = IR[RA_LSB +: REG_W];
  assign rb        = IR[RB_LSB +: REG_W];
  assign rc        = IR[RC_LSB +: REG_W];
  assign op_class  = classify_op(opcode);
  assign op_muldiv = is_muldiv(opcode);
  assign unused_ir_bits = ^IR[RC_LSB-1:0];

  // No instruction in this set transfers HI/LO back onto the bus.
  assign HIout = 1'b0;
  assign LOout = 1'b0;

  assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted = (state_q == S_HALT);

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The T1 wait counter only advances while the memory read is still pending,
  // so it reads zero on every entry into T1.
  always_comb begin
    cnt_d = '0;
    if ((state_q == S_T1) && (cnt_q != WAIT_LAST)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    alu_op   = '0;
    illegal  = 1'b0;
    rin_en   = 1'b0;
    rin_idx  = ra;
    rout_en  = 1'b0;
    rout_idx = rb;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_T0;
      end
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Read = 1'b1;
        if (cnt_q == 4'd0) begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
        end
        if (cnt_q == WAIT_LAST) begin
          MDRin   = 1'b1;
          state_d = S_T2;
        end
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        case (op_class)
          CLS_BINARY: begin
            rout_en  = 1'b1;
            rout_idx = rb;
            Yin      = 1'b1;
            state_d  = S_T4;
          end
          CLS_UNARY:   state_d = S_T4;
          CLS_HALT:    state_d = S_HALT;
          CLS_ILLEGAL: begin
            illegal = 1'b1;
            state_d = run ? S_T0 : S_IDLE;
          end
          default:     state_d = run ? S_T0 : S_IDLE;
        endcase
      end
      // Unary ops take their single operand from rb; binary ops pair Y with rc.
      S_T4: begin
        alu_op   = opcode;
        Zin      = 1'b1;
        rout_en  = 1'b1;
        rout_idx = (op_class == CLS_UNARY) ? rb : rc;
        state_d  = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (op_muldiv) begin
          LOin    = 1'b1;
          state_d = S_T6;
        end else begin
          rin_en  = 1'b1;
          rin_idx = ra;
          state_d = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        state_d  = run ? S_T0 : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  reg_select_decoder u_rin_dec (
    .idx_i    (rin_idx),
    .en_i     (rin_en),
    .onehot_o (Rin)
  );

  reg_select_decoder u_rout_dec (
    .idx_i    (rout_idx),
    .en_i     (rout_en),
    .onehot_o (Rout)
  );

endmodule
